// File: rtl/fp_adder_32bit.sv
// fp_adder_32bit: binary32 adder, round to nearest even. The result appears two edges after the operands are sampled.
// FP_ADDER_SUBNORMAL_EN selects gradual underflow; when it is undefined, subnormal inputs and results flush to zero.
module fp_adder_32bit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_vld,
    output logic [31:0] o_res,
    output logic        o_res_vld,
    output logic        overflow
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    logic        v0, v1;
    logic [31:0] a_r, b_r;
    logic        sa, sb, nan_a, nan_b, inf_a, inf_b, swap, sub_w, spec_w;
    logic [7:0]  ea, eb, el, es, d;
    logic [23:0] ma, mb;
    logic [26:0] ms_full, ms_sh;
    logic [31:0] spec_val_w;
    logic        sub_r, sl_r, fs_r, spec_r;
    logic [7:0]  el_r;
    logic [26:0] ml_r, ms_r;
    logic [31:0] spec_val_r;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [26:0] nm;
    logic [8:0]  e_adj, ef;
    logic [24:0] rm;
    logic        rnd, tiny, ovf_w;
    logic [31:0] res_w;
    always_comb begin
        sa = a_r[31];
        sb = b_r[31];
        nan_a = (&a_r[30:23]) & (|a_r[22:0]);
        nan_b = (&b_r[30:23]) & (|b_r[22:0]);
        inf_a = (&a_r[30:23]) & ~(|a_r[22:0]);
        inf_b = (&b_r[30:23]) & ~(|b_r[22:0]);
        ea = (a_r[30:23] == 8'd0) ? 8'd1 : a_r[30:23];
        eb = (b_r[30:23] == 8'd0) ? 8'd1 : b_r[30:23];
`ifdef FP_ADDER_SUBNORMAL_EN
        ma = {|a_r[30:23], a_r[22:0]};
        mb = {|b_r[30:23], b_r[22:0]};
`else
        ma = (|a_r[30:23]) ? {1'b1, a_r[22:0]} : 24'd0;
        mb = (|b_r[30:23]) ? {1'b1, b_r[22:0]} : 24'd0;
`endif
        swap = {eb, mb} > {ea, ma};
        el = swap ? eb : ea;
        es = swap ? ea : eb;
        d = el - es;
        ms_full = {swap ? ma : mb, 3'b000};
        ms_sh = ms_full >> d;
        sub_w = sa ^ sb;
        spec_w = nan_a | nan_b | inf_a | inf_b;
        spec_val_w = (nan_a | nan_b | (inf_a & inf_b & sub_w)) ? QNAN : {inf_a ? sa : sb, 8'hFF, 23'd0};
    end
    // Shifts past the 27-bit width collapse to zero, so everything shifted out lands in sticky.
    always_ff @(posedge clk) begin
        a_r <= i_a;
        b_r <= i_b;
        sub_r <= sub_w;
        sl_r <= swap ? sb : sa;
        fs_r <= sa & sb;
        spec_r <= spec_w;
        spec_val_r <= spec_val_w;
        el_r <= el;
        ml_r <= {swap ? mb : ma, 3'b000};
        ms_r <= {ms_sh[26:1], ms_sh[0] | (|(ms_full & ~(27'h7FF_FFFF << d)))};
    end
    always_comb begin
        sum = sub_r ? {1'b0, ml_r} - {1'b0, ms_r} : {1'b0, ml_r} + {1'b0, ms_r};
        lz = 5'd27;
        for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
`ifdef FP_ADDER_SUBNORMAL_EN
        tiny = 1'b0;
        sh = ({3'b000, lz} < el_r) ? lz : 5'(el_r - 8'd1);
`else
        tiny = ~sum[27] & ({3'b000, lz} >= el_r);
        sh = lz;
`endif
        nm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
        e_adj = sum[27] ? {1'b0, el_r} + 9'd1 : {1'b0, el_r} - {4'd0, sh};
        rnd = nm[2] & (nm[1] | nm[0] | nm[3]);
        rm = {1'b0, nm[26:3]} + {24'd0, rnd};
        // A leading bit below position 23 means a subnormal result with exponent field 0.
        ef = rm[24] ? e_adj + 9'd1 : (rm[23] ? e_adj : 9'd0);
        ovf_w = 1'b0;
        res_w = {sl_r, ef[7:0], rm[24] ? rm[23:1] : rm[22:0]};
        if (spec_r) res_w = spec_val_r;
        else if (sum == 28'd0) res_w = {~sub_r & sl_r, 31'd0};
        else if (tiny) res_w = {fs_r, 31'd0};
        else if (ef >= 9'd255) begin
            res_w = {sl_r, 8'hFF, 23'd0};
            ovf_w = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            o_res_vld <= 1'b0;
            overflow <= 1'b0;
            o_res <= 32'd0;
        end else begin
            v0 <= i_vld;
            v1 <= v0;
            o_res_vld <= v1;
            overflow <= v1 & ovf_w;
            if (v1) o_res <= res_w;
        end
    end
endmodule

// File: tb/tb_fp_adder_32bit.sv
// tb_fp_adder_32bit: scoreboard bench for fp_adder_32bit; the reference adds exact scaled integers and rounds once.
// Honours FP_ADDER_SUBNORMAL_EN the same way the design does.
module tb_fp_adder_32bit;
    logic        clk = 1'b0, rst = 1'b1, i_vld = 1'b0;
    logic [31:0] i_a = 32'd0, i_b = 32'd0, o_res;
    logic        o_res_vld, overflow;
    int          n_chk = 0, n_pass = 0, cyc = 0;
    logic [32:0] exp_q[$];
    int          cyc_q[$];
    logic [31:0] last_res = 32'd0;
    logic [32:0] m_exp;
    int          m_cyc;

    fp_adder_32bit dut (.clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_vld(i_vld),
                        .o_res(o_res), .o_res_vld(o_res_vld), .overflow(overflow));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Value in units of 2^-149, which makes every finite binary32 an integer.
    function automatic logic [279:0] mag(input logic [31:0] x);
`ifdef FP_ADDER_SUBNORMAL_EN
        if (x[30:23] == 8'd0) return 280'(x[22:0]);
`else
        if (x[30:23] == 8'd0) return '0;
`endif
        return 280'({1'b1, x[22:0]}) << (x[30:23] - 8'd1);
    endfunction

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [279:0] ma, mb, m, rem, half;
        logic [24:0]  s;
        logic         sr, na, nb, ia, ib;
        int           p, sh, e;
        na = (&a[30:23]) && (|a[22:0]);
        nb = (&b[30:23]) && (|b[22:0]);
        ia = (&a[30:23]) && !(|a[22:0]);
        ib = (&b[30:23]) && !(|b[22:0]);
        if (na || nb || (ia && ib && a[31] != b[31])) return {1'b0, 32'h7FC0_0000};
        if (ia) return {1'b0, a};
        if (ib) return {1'b0, b};
        ma = mag(a);
        mb = mag(b);
        if (a[31] == b[31]) begin m = ma + mb; sr = a[31]; end
        else if (ma >= mb) begin m = ma - mb; sr = a[31]; end
        else begin m = mb - ma; sr = b[31]; end
        if (m == 0) return {1'b0, a[31] & b[31], 31'd0};
        p = 0;
        for (int i = 0; i < 280; i++) if (m[i]) p = i;
        if (p < 23) begin
`ifdef FP_ADDER_SUBNORMAL_EN
            return {1'b0, sr, 31'(m)};
`else
            return {1'b0, a[31] & b[31], 31'd0};
`endif
        end
        if (p == 23) return {1'b0, sr, 8'd1, m[22:0]};
        sh = p - 23;
        s = 25'(m >> sh);
        rem = m & ((280'd1 << sh) - 280'd1);
        half = 280'd1 << (sh - 1);
        if (rem > half || (rem == half && s[0])) s = s + 25'd1;
        e = sh + 1;
        if (s[24]) begin s = s >> 1; e++; end
        if (e >= 255) return {1'b1, sr, 8'hFF, 23'd0};
        return {1'b0, sr, 8'(e), s[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k >= 4 && k <= 6) r[30:23] = 8'(118 + $urandom_range(0, 16));
        else if (k == 7) r[30:23] = 8'($urandom_range(0, 2));
        else if (k == 8) r[30:23] = 8'($urandom_range(250, 254));
        else if (k == 9) begin
            case ($urandom_range(0, 4))
                0: r[30:0] = 31'd0;
                1: r[30:0] = 31'h7F80_0000;
                2: r[30:22] = 9'h1FF;
                3: r[30:0] = 31'h7F7F_FFFF;
                default: r[30:0] = 31'h0080_0000;
            endcase
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [32:0] want);
        i_a = a;
        i_b = b;
        i_vld = 1'b1;
        exp_q.push_back(want);
        cyc_q.push_back(cyc + 3);
        @(posedge clk); #1;
        i_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        i_vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) last_res = 32'd0;
        else if (o_res_vld) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_vld: got o_res_vld=1 o_res=%h expected no result", o_res);
            end else begin
                m_exp = exp_q.pop_front();
                m_cyc = cyc_q.pop_front();
                check("res", 64'(o_res), 64'(m_exp[31:0]));
                check("ovf", 64'(overflow), 64'(m_exp[32]));
                check("latency", 64'(cyc), 64'(m_cyc));
            end
            last_res = o_res;
        end else begin
            check("hold_res", 64'(o_res), 64'(last_res));
            check("idle_ovf", 64'(overflow), 64'd0);
        end
    end

    initial begin
        logic [31:0] a, b;
        #1;
        check("rst_res", 64'(o_res), 64'd0);
        check("rst_vld", 64'(o_res_vld), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h4060_0000, 32'hC010_0000, {1'b0, 32'h3FA0_0000});
        idle(2);
        send(32'h3F80_0000, 32'h4000_0000, {1'b0, 32'h4040_0000});
        send(32'hC090_0000, 32'h4020_0000, {1'b0, 32'hC000_0000});
        send(32'h3F00_0000, 32'h3E80_0000, {1'b0, 32'h3F40_0000});
        send(32'h8000_0000, 32'h0000_0000, {1'b0, 32'h0000_0000});
        send(32'h8000_0000, 32'h8000_0000, {1'b0, 32'h8000_0000});
        send(32'h3F80_0000, 32'hBF80_0000, {1'b0, 32'h0000_0000});
        send(32'h7FC0_0000, 32'h3F80_0000, {1'b0, 32'h7FC0_0000});
        send(32'h7F80_0000, 32'h3F80_0000, {1'b0, 32'h7F80_0000});
        send(32'hFF80_0000, 32'h3F80_0000, {1'b0, 32'hFF80_0000});
        send(32'h7F80_0000, 32'h7F80_0000, {1'b0, 32'h7F80_0000});
        send(32'hFF80_0000, 32'hFF80_0000, {1'b0, 32'hFF80_0000});
        send(32'h7F80_0000, 32'hFF80_0000, {1'b0, 32'h7FC0_0000});
        send(32'hFF80_0000, 32'h7F80_0000, {1'b0, 32'h7FC0_0000});
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, {1'b1, 32'h7F80_0000});
        send(32'hFF7F_FFFF, 32'hFF7F_FFFF, {1'b1, 32'hFF80_0000});
        send(32'h3F80_0000, 32'h3380_0000, {1'b0, 32'h3F80_0000});
        send(32'h3F80_0001, 32'h3380_0000, {1'b0, 32'h3F80_0002});
`ifdef FP_ADDER_SUBNORMAL_EN
        send(32'h0080_0001, 32'h8080_0000, {1'b0, 32'h0000_0001});
`else
        send(32'h0080_0001, 32'h8080_0000, {1'b0, 32'h0000_0000});
`endif
        idle(4);
        i_a = 32'h3F80_0000;
        i_b = 32'h4000_0000;
        i_vld = 1'b1;
        @(posedge clk); #1;
        i_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_res", 64'(o_res), 64'd0);
        check("async_rst_vld", 64'(o_res_vld), 64'd0);
        check("async_rst_ovf", 64'(overflow), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);
        for (int n = 0; n < 600; n++) begin
            a = rand_fp();
            b = ($urandom_range(0, 4) == 0) ? {~a[31], a[30:0] ^ 31'($urandom_range(0, 7))} : rand_fp();
            send(a, b, ref_add(a, b));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
